// File: rtl/nn_mem_pkg.sv
// Shared definitions for the memory stream reader block.
// Contents:
//   reader_state_e - burst sequencer states (IDLE, READ, DRAIN)
//   SKID_ENTRIES   - depth of the output skid buffer (2 words)
//   burst_len_t    - burst length type, BURST_DEPTH+1 bits (0..2**BURST_DEPTH words)
//   BURST_ONE      - burst_len_t constant 1, used to detect the final read
// BURST_DEPTH must track the DEPTH parameter of mem_stream_reader.
package nn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  localparam int SKID_ENTRIES = 2;
  localparam int BURST_DEPTH  = 8;

  typedef logic [BURST_DEPTH:0] burst_len_t;

  localparam burst_len_t BURST_ONE = {{BURST_DEPTH{1'b0}}, 1'b1};

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer between the memory read pipeline and the stream port.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - write side; in_ready is low only when both entries are full
//   in_data             - word written on in_valid & in_ready
//   out_valid/out_ready - stream side; a word leaves on out_valid & out_ready
//   out_data            - head entry, held stable while stalled
// The head entry is the output register; the spare entry catches the word that
// arrives while the head is stalled, so the output never changes under a stall.
module stream_skid_buffer #(
  parameter int BIT_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data
);

  logic [BIT_SIZE-1:0] head_r;
  logic [BIT_SIZE-1:0] spare_r;
  logic                head_v_r;
  logic                spare_v_r;
  logic                push_s;
  logic                pop_s;

  assign in_ready  = ~spare_v_r;
  assign push_s    = in_valid & ~spare_v_r;
  assign pop_s     = head_v_r & out_ready;
  assign out_valid = head_v_r;
  assign out_data  = head_r;

  // Entry storage: pop promotes the spare to head, push fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r    <= {BIT_SIZE{1'b0}};
      spare_r   <= {BIT_SIZE{1'b0}};
      head_v_r  <= 1'b0;
      spare_v_r <= 1'b0;
    end else begin
      if (pop_s) begin
        if (spare_v_r) begin
          // Spare present means in_ready was low, so no push this cycle.
          head_r    <= spare_r;
          spare_v_r <= 1'b0;
        end else if (push_s) begin
          head_r <= in_data;
        end else begin
          head_v_r <= 1'b0;
        end
      end else if (push_s) begin
        if (head_v_r) begin
          spare_r   <= in_data;
          spare_v_r <= 1'b1;
        end else begin
          head_r   <= in_data;
          head_v_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: walks a memory from base_addr for length words and streams
// the read data out over a valid/ready port.
// Optional feature macro: STREAM_STRIDE_EN adds the stride input (address
// increment sampled with start); without it the increment is fixed at 1.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - one-cycle burst request, honoured only when idle
//   base_addr, length    - burst first address and word count, sampled on start
//   stride               - address increment (STREAM_STRIDE_EN only)
//   read_addr            - memory read address; mem_data returns one cycle later
//   mem_data             - memory read data
//   out_data/out_valid/out_ready/out_last - output stream
//   busy                 - burst in progress
//   done                 - one-cycle pulse after the burst's final handshake
module mem_stream_reader
  import nn_mem_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DEPTH-1:0]    base_addr,
`ifdef STREAM_STRIDE_EN
  input  logic [DEPTH-1:0]    stride,
`endif
  input  logic [DEPTH:0]      length,
  output logic [DEPTH-1:0]    read_addr,
  input  logic [BIT_SIZE-1:0] mem_data,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] SKID_LIMIT = 2'(SKID_ENTRIES);

  reader_state_e       state_r;
  reader_state_e       state_nxt_s;
  logic [DEPTH-1:0]    addr_r;
  logic [DEPTH-1:0]    step_s;
  burst_len_t          issue_left_r;
  logic                data_v_r;
  logic                data_last_r;
  logic                busy_r;
  logic                done_r;
  logic                accept_s;
  logic                empty_s;
  logic                issue_s;
  logic                last_issue_s;
  logic                pop_s;
  logic                last_pop_s;
  logic [1:0]          occupancy_s;
  logic [1:0]          remaining_s;
  logic                buf_valid_s;
  logic                buf_ready_s;
  logic [BIT_SIZE:0]   buf_word_s;

`ifdef STREAM_STRIDE_EN
  logic [DEPTH-1:0] stride_r;
  assign step_s = stride_r;
`else
  assign step_s = {{(DEPTH-1){1'b0}}, 1'b1};
`endif

  assign accept_s   = (state_r == IDLE) && start && (length != {(DEPTH+1){1'b0}});
  assign empty_s    = (state_r == IDLE) && start && (length == {(DEPTH+1){1'b0}});
  assign pop_s      = buf_valid_s & out_ready;
  assign last_pop_s = pop_s & buf_word_s[BIT_SIZE];

  // Words in flight (mem_data this cycle) plus words held in the buffer; the
  // buffer is full exactly when it refuses input.
  assign occupancy_s = {1'b0, data_v_r} + {1'b0, buf_valid_s} + {1'b0, ~buf_ready_s};
  // Discount the beat leaving this cycle so a read can be issued every cycle
  // under a continuously ready consumer without ever overrunning two entries.
  assign remaining_s = occupancy_s - {1'b0, pop_s};

  // Read issue decision for the address currently on read_addr.
  always_comb begin
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    if ((state_r == READ) && (remaining_s < SKID_LIMIT)) begin
      issue_s      = 1'b1;
      last_issue_s = (issue_left_r == BURST_ONE);
    end else begin
      issue_s      = 1'b0;
      last_issue_s = 1'b0;
    end
  end

  // Next-state logic of the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (last_issue_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (last_pop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address/count datapath, read pipeline tag and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= {DEPTH{1'b0}};
      issue_left_r <= {(BURST_DEPTH+1){1'b0}};
      data_v_r     <= 1'b0;
      data_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef STREAM_STRIDE_EN
      stride_r     <= {DEPTH{1'b0}};
`endif
    end else begin
      done_r      <= empty_s | ((state_r == DRAIN) & last_pop_s);
      busy_r      <= (state_nxt_s != IDLE);
      data_v_r    <= issue_s;
      data_last_r <= last_issue_s;
      if (accept_s) begin
        addr_r       <= base_addr;
        issue_left_r <= length;
`ifdef STREAM_STRIDE_EN
        stride_r     <= stride;
`endif
      end else if (issue_s) begin
        issue_left_r <= issue_left_r - BURST_ONE;
        // The final address stays on read_addr once the burst is fully issued.
        if (!last_issue_s) begin
          addr_r <= addr_r + step_s;
        end
      end
    end
  end

  // Each buffered word carries its end-of-burst flag in the top bit.
  stream_skid_buffer #(
    .BIT_SIZE (BIT_SIZE + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (data_v_r),
    .in_ready  (buf_ready_s),
    .in_data   ({data_last_r, mem_data}),
    .out_valid (buf_valid_s),
    .out_ready (out_ready),
    .out_data  (buf_word_s)
  );

  assign read_addr = addr_r;
  assign out_valid = buf_valid_s;
  assign out_data  = buf_word_s[BIT_SIZE-1:0];
  assign out_last  = buf_valid_s & buf_word_s[BIT_SIZE];
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader (DEPTH=8, BIT_SIZE=16).
// The memory model returns data equal to the address one cycle after read_addr.
// Stimulus pushes expected beats; a monitor pops and compares on each handshake.
module tb_mem_stream_reader;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
`ifdef STREAM_STRIDE_EN
  logic [7:0]  stride;
`endif
  logic [8:0]  length;
  logic [7:0]  read_addr;
  logic [15:0] mem_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  beat_t      exp_q[$];
  logic [7:0] addr_log[$];
  bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  mem_stream_reader #(
    .DEPTH    (8),
    .BIT_SIZE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
`ifdef STREAM_STRIDE_EN
    .stride    (stride),
`endif
    .length    (length),
    .read_addr (read_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data equals address.
  always @(posedge clk) mem_data <= {8'h00, read_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stall stability and in-order scoreboard comparison.
  initial begin
    bit          held_v;
    logic [15:0] held_d;
    beat_t       e;
    held_v = 1'b0;
    held_d = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {16'd0, out_data}, {16'd0, held_d});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", {16'd0, out_data}, {16'd0, e.data});
            chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
          end
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
      end
    end
  end

  // Log each distinct address presented while a burst is active.
  initial begin
    forever begin
      @(negedge clk);
      if (busy && (addr_log.size() == 0 || addr_log[$] != read_addr))
        addr_log.push_back(read_addr);
    end
  end

  task automatic run_burst(input logic [7:0] base, input logic [8:0] len,
                           input logic [7:0] strd, input bit toggle,
                           output int first_valid, output int done_at,
                           output bit saw_busy, output bit busy_at_done);
    logic [7:0] a;
    beat_t      b;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      b.data = {8'h00, a};
      b.last = (i == int'(len) - 1);
      exp_q.push_back(b);
      a = a + strd;
    end
    addr_log.delete();
    base_addr = base;
    length    = len;
`ifdef STREAM_STRIDE_EN
    stride    = strd;
`endif
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_valid  = -1;
    done_at      = -1;
    saw_busy     = 1'b0;
    busy_at_done = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid && first_valid < 0) first_valid = k;
      if (done) begin
        done_at      = k;
        busy_at_done = busy;
        break;
      end
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      if (toggle) out_ready = pat[(k + 1) % 4];
    end
    if (done_at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    @(negedge clk);
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    int fv, da;
    bit sb, bd;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 8'h00;
    length    = 9'd0;
    out_ready = 1'b1;
`ifdef STREAM_STRIDE_EN
    stride    = 8'h01;
`endif
    #12;
    chk("rst_read_addr", {24'd0, read_addr}, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic burst: latency 2, one beat per cycle, done right after the last beat.
    run_burst(8'h10, 9'd4, 8'h01, 1'b0, fv, da, sb, bd);
    chk("t1_first_valid", fv, 32'd2);
    chk("t1_done_at", da, 32'd6);
    chk("t1_busy_seen", {31'd0, sb}, 32'd1);
    chk("t1_busy_at_done", {31'd0, bd}, 32'd0);
    chk("t1_addr_count", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      chk("t1_addr0", {24'd0, addr_log[0]}, 32'h10);
      chk("t1_addr3", {24'd0, addr_log[3]}, 32'h13);
    end

    // Wrapping burst.
    run_burst(8'hFE, 9'd4, 8'h01, 1'b0, fv, da, sb, bd);
    chk("t2_done_at", da, 32'd6);
    chk("t2_addr_count", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      chk("t2_addr0", {24'd0, addr_log[0]}, 32'hFE);
      chk("t2_addr1", {24'd0, addr_log[1]}, 32'hFF);
      chk("t2_addr2", {24'd0, addr_log[2]}, 32'h00);
      chk("t2_addr3", {24'd0, addr_log[3]}, 32'h01);
    end

    // Back-pressure with ready pattern 1,0,0,1.
    run_burst(8'h30, 9'd8, 8'h01, 1'b1, fv, da, sb, bd);
    chk("t3_busy_at_done", {31'd0, bd}, 32'd0);

    // Empty burst.
    run_burst(8'h55, 9'd0, 8'h01, 1'b0, fv, da, sb, bd);
    chk("t4_done_at", da, 32'd0);
    chk("t4_no_valid", fv, 32'hFFFF_FFFF);
    chk("t4_no_busy", {31'd0, sb}, 32'd0);
    chk("t4_busy_at_done", {31'd0, bd}, 32'd0);

    // Reset two beats into a six-beat burst.
    begin
      beat_t b;
      b.last = 1'b0;
      b.data = 16'h0040; exp_q.push_back(b);
      b.data = 16'h0041; exp_q.push_back(b);
    end
    base_addr = 8'h40;
    length    = 9'd6;
`ifdef STREAM_STRIDE_EN
    stride    = 8'h01;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_addr", {24'd0, read_addr}, 32'h0);
    chk("t5_rst_last", {31'd0, out_last}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_two_beats", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    // Start presented before the first edge after reset release.
    run_burst(8'h20, 9'd3, 8'h01, 1'b0, fv, da, sb, bd);
    chk("t5_restart_done_at", da, 32'd5);
    chk("t5_restart_first_valid", fv, 32'd2);

`ifdef STREAM_STRIDE_EN
    run_burst(8'h00, 9'd3, 8'h04, 1'b0, fv, da, sb, bd);
    chk("t6_addr_count", addr_log.size(), 32'd3);
    if (addr_log.size() == 3) begin
      chk("t6_addr0", {24'd0, addr_log[0]}, 32'h00);
      chk("t6_addr1", {24'd0, addr_log[1]}, 32'h04);
      chk("t6_addr2", {24'd0, addr_log[2]}, 32'h08);
    end
    run_burst(8'h00, 9'd3, 8'h00, 1'b0, fv, da, sb, bd);
    chk("t7_done_at", da, 32'd5);
    chk("t7_addr_count", addr_log.size(), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 8: address width; the memory holds 2**DEPTH words.
REQ-002 SHALL have parameter BIT_SIZE, default 16: data word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a burst.
REQ-006 SHALL have port base_addr, input, DEPTH bits: first word address, sampled when start is accepted.
REQ-007 SHALL have port length, input, DEPTH+1 bits: number of words in the burst (0..2**DEPTH), sampled when start is accepted.
REQ-008 SHALL have port read_addr, output, DEPTH bits: address driven to the memory read port.
REQ-009 SHALL have port mem_data, input, BIT_SIZE bits: memory read data, valid exactly one cycle after read_addr is driven.
REQ-010 SHALL have port out_data, output, BIT_SIZE bits: stream data.
REQ-011 SHALL have port out_valid, output, 1 bit: stream data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-013 SHALL have port out_last, output, 1 bit: the current beat is the final word of the burst.
REQ-014 SHALL have port busy, output, 1 bit: high while a burst is active.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-016 SHALL use FSM states IDLE, READ and DRAIN.
- IDLE -> READ: start=1 with length>0.
- READ -> DRAIN: last address issued.
- DRAIN -> IDLE: last beat accepted.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL treat start with length=0 as an empty burst: stay in IDLE, pulse done on the next cycle, emit no beats.
REQ-019 SHALL issue a read (advance read_addr) only while outstanding reads plus buffered words total less than 2.
REQ-020 SHALL hold read_addr at its last value when no read is issued.
REQ-021 SHALL add the stride to the address on each issued read, modulo 2**DEPTH, so bursts wrap (base 0xFE, length 4 -> 0xFE, 0xFF, 0x00, 0x01).
REQ-022 SHALL capture every mem_data word into a 2-entry skid buffer in the cycle after its read is issued, never dropping it, regardless of out_ready.
REQ-023 SHALL present beats in address-issue order; a beat transfers when out_valid and out_ready are both 1.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert out_last with the beat numbered length-1 only.
REQ-026 SHALL pulse done in the cycle after the last-beat handshake; busy SHALL fall in that same cycle.
REQ-027 SHALL give a first-beat latency of 2 cycles from start to out_valid, with out_ready held at 1.
REQ-028 SHALL sustain 1 beat per cycle when out_ready is held at 1.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: FSM to IDLE, read_addr=0, out_valid=0, out_last=0, busy=0, done=0, skid buffer empty, counters=0.
REQ-030 SHALL abort any burst in progress when reset is asserted; no done pulse follows.
REQ-031 SHALL accept start on the first clock edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with STREAM_STRIDE_EN defined, add input stride (DEPTH bits), sampled with start, used as the address increment; stride=0 re-reads base_addr length times.
REQ-033 SHALL, without STREAM_STRIDE_EN, have no stride port and use a fixed increment of 1.

Structure
REQ-034 SHALL take the FSM state enum, the burst-length typedef (DEPTH+1 bits) and the SKID_ENTRIES=2 constant from the shared package nn_mem_pkg.
REQ-035 SHALL implement the 2-entry buffer as sub-module stream_skid_buffer (valid/ready in and out, parameter BIT_SIZE).

Verification
REQ-036 Bench SHALL drive base=0x10, length=4, out_ready=1 (memory holds data=addr) -> beats 0x10..0x13 on consecutive cycles, out_last on 0x13, done one cycle later.
REQ-037 Bench SHALL drive base=0xFE, length=4 -> read_addr sequence 0xFE, 0xFF, 0x00, 0x01; data in the same order.
REQ-038 Bench SHALL drive length=8 with out_ready toggling 1,0,0,1 repeatedly -> all 8 words in order, none duplicated or lost, out_data stable while stalled.
REQ-039 Bench SHALL drive start with length=0 -> done pulses next cycle, out_valid stays 0, busy stays 0.
REQ-040 Bench SHALL assert rst_n=0 mid-burst, after 2 of 6 beats -> outputs reach reset values immediately, no done pulse; a new start of length 3 then completes normally.
REQ-041 Bench SHALL, with STREAM_STRIDE_EN defined, drive base=0x00, stride=4, length=3 -> addresses 0x00, 0x04, 0x08; with stride=0 -> 0x00 read three times.
